// File: rtl/ysyx_23060072_scoreboard_pkg.sv
// Shared constants and types for the load-use scoreboard.
package ysyx_23060072_scoreboard_pkg;

  localparam int unsigned NREG_DEF   = 16;
  localparam int unsigned CNT_W_DEF  = 2;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned X0_IDX     = 0;

  typedef logic [CNT_W_DEF-1:0] pend_cnt_t;

endpackage

// File: rtl/ysyx_23060072_sb_entry.sv
// Per-register pending-load counter: up/down, saturating, with an error pulse on
// underflow or overflow.
module ysyx_23060072_sb_entry #(
  parameter int unsigned CntW = 2
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            inc_i,
  input  logic            dec_i,
  output logic [CntW-1:0] cnt_o,
  output logic            err_o
);

  localparam logic [CntW-1:0] CntMax = '1;
  localparam logic [CntW-1:0] CntOne = CntW'(1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    err_o = 1'b0;
    if (inc_i && !dec_i) begin
      if (cnt_q == CntMax) err_o = 1'b1;
      else                 cnt_d = cnt_q + CntOne;
    end else if (dec_i && !inc_i) begin
      if (cnt_q == '0) err_o = 1'b1;
      else             cnt_d = cnt_q - CntOne;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/ysyx_23060072_scoreboard.sv
// Load-use hazard tracker between ID and ID/EX: counts in-flight loads per rd and
// stalls ID while a source register still waits on one.
module ysyx_23060072_scoreboard
  import ysyx_23060072_scoreboard_pkg::*;
#(
  parameter int unsigned NREG           = NREG_DEF,
  parameter int unsigned CNT_W          = CNT_W_DEF,
  parameter bit          STORE_DATA_FWD = 1'b0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  id_valid,
  output logic                  id_ready,
  input  logic                  flush,
  input  logic                  id_has_rs1,
  input  logic                  id_has_rs2,
  input  logic [REG_ADDR_W-1:0] id_rs1_addr,
  input  logic [REG_ADDR_W-1:0] id_rs2_addr,
  input  logic                  id_is_load,
  input  logic                  id_is_store,
  input  logic                  id_wb_flag,
  input  logic [REG_ADDR_W-1:0] id_wb_addr,
  input  logic                  load_done,
  input  logic [REG_ADDR_W-1:0] load_done_addr,
  output logic                  stall,
  output logic                  hazard_rs1,
  output logic                  hazard_rs2,
  output logic [31:0]           stall_cnt,
  output logic                  sb_err
);

  localparam int unsigned IdxW = $clog2(NREG);
  localparam logic [IdxW-1:0] X0 = IdxW'(X0_IDX);
  localparam logic [CNT_W-1:0] CntMax = '1;

  logic [IdxW-1:0] rs1_idx, rs2_idx, rd_idx, done_idx;
  logic [CNT_W-1:0] pend [NREG];
  logic [NREG-1:1]  err_vec;
  logic [CNT_W-1:0] eff_rs1, eff_rs2;
  logic             full, issue;
  logic [31:0]      stall_cnt_q, stall_cnt_d;
  logic             sb_err_q, sb_err_d;
  logic             unused_addr_msb;

  // Upper address bits are always 0 for RV32E.
  assign rs1_idx  = id_rs1_addr[IdxW-1:0];
  assign rs2_idx  = id_rs2_addr[IdxW-1:0];
  assign rd_idx   = id_wb_addr[IdxW-1:0];
  assign done_idx = load_done_addr[IdxW-1:0];
  assign unused_addr_msb = ^{id_rs1_addr[REG_ADDR_W-1:IdxW], id_rs2_addr[REG_ADDR_W-1:IdxW],
                             id_wb_addr[REG_ADDR_W-1:IdxW], load_done_addr[REG_ADDR_W-1:IdxW]};

  assign pend[0] = '0;

  for (genvar i = 1; i < NREG; i++) begin : g_entry
    logic inc, dec;
    assign inc = issue && id_is_load && id_wb_flag && (rd_idx == IdxW'(i));
    assign dec = load_done && (done_idx == IdxW'(i));
    ysyx_23060072_sb_entry #(
      .CntW (CNT_W)
    ) u_entry (
      .clock (clock),
      .reset (reset),
      .inc_i (inc),
      .dec_i (dec),
      .cnt_o (pend[i]),
      .err_o (err_vec[i])
    );
  end

  // A load completing this cycle is forwardable next cycle, so discount it.
  assign eff_rs1 = pend[rs1_idx] - CNT_W'(load_done && (done_idx == rs1_idx));
  assign eff_rs2 = pend[rs2_idx] - CNT_W'(load_done && (done_idx == rs2_idx));

  always_comb begin
    hazard_rs1 = id_valid && id_has_rs1 && (rs1_idx != X0) && (eff_rs1 != '0);
    hazard_rs2 = id_valid && id_has_rs2 && (rs2_idx != X0) && (eff_rs2 != '0);
    if (STORE_DATA_FWD && id_is_store && !hazard_rs1) hazard_rs2 = 1'b0;
    full     = id_valid && id_is_load && id_wb_flag && (rd_idx != X0) && (pend[rd_idx] == CntMax);
    stall    = hazard_rs1 || hazard_rs2 || full;
    id_ready = !stall;
    issue    = id_valid && id_ready && !flush;
  end

  assign stall_cnt_d = stall ? stall_cnt_q + 32'd1 : stall_cnt_q;
  assign sb_err_d    = sb_err_q || (|err_vec);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
      sb_err_q    <= 1'b0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      sb_err_q    <= sb_err_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign sb_err    = sb_err_q;

endmodule

// File: tb/tb_ysyx_23060072_scoreboard.sv
// Randomized + directed bench for the scoreboard; runs both store-forwarding modes
// side by side against a counting reference model.
module tb_ysyx_23060072_scoreboard;
  import ysyx_23060072_scoreboard_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic id_valid, flush, id_has_rs1, id_has_rs2, id_is_load, id_is_store, id_wb_flag;
  logic [4:0] id_rs1_addr, id_rs2_addr, id_wb_addr, load_done_addr;
  logic load_done;

  logic [1:0]  id_ready_v, stall_v, hz1_v, hz2_v, err_v;
  logic [31:0] scnt_v [2];

  int n_checks = 0;
  int n_errors = 0;

  // Reference state per mode: index 0 = no store-data forwarding, 1 = forwarding.
  int          pend_m [2][16];
  int unsigned scnt_m [2];
  bit          err_m  [2];

  always #5 clock = ~clock;

  ysyx_23060072_scoreboard #(.STORE_DATA_FWD(1'b0)) u_dut_nofwd (
    .clock (clock), .reset (reset), .id_valid (id_valid), .id_ready (id_ready_v[0]),
    .flush (flush), .id_has_rs1 (id_has_rs1), .id_has_rs2 (id_has_rs2),
    .id_rs1_addr (id_rs1_addr), .id_rs2_addr (id_rs2_addr), .id_is_load (id_is_load),
    .id_is_store (id_is_store), .id_wb_flag (id_wb_flag), .id_wb_addr (id_wb_addr),
    .load_done (load_done), .load_done_addr (load_done_addr), .stall (stall_v[0]),
    .hazard_rs1 (hz1_v[0]), .hazard_rs2 (hz2_v[0]), .stall_cnt (scnt_v[0]), .sb_err (err_v[0])
  );

  ysyx_23060072_scoreboard #(.STORE_DATA_FWD(1'b1)) u_dut_fwd (
    .clock (clock), .reset (reset), .id_valid (id_valid), .id_ready (id_ready_v[1]),
    .flush (flush), .id_has_rs1 (id_has_rs1), .id_has_rs2 (id_has_rs2),
    .id_rs1_addr (id_rs1_addr), .id_rs2_addr (id_rs2_addr), .id_is_load (id_is_load),
    .id_is_store (id_is_store), .id_wb_flag (id_wb_flag), .id_wb_addr (id_wb_addr),
    .load_done (load_done), .load_done_addr (load_done_addr), .stall (stall_v[1]),
    .hazard_rs1 (hz1_v[1]), .hazard_rs2 (hz2_v[1]), .stall_cnt (scnt_v[1]), .sb_err (err_v[1])
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic idle();
    id_valid = 0; flush = 0; id_has_rs1 = 0; id_has_rs2 = 0; id_is_load = 0;
    id_is_store = 0; id_wb_flag = 0; id_rs1_addr = 0; id_rs2_addr = 0; id_wb_addr = 0;
    load_done = 0; load_done_addr = 0;
  endtask

  task automatic set_load(input int rd, input int base);
    idle();
    id_valid = 1; id_is_load = 1; id_wb_flag = 1; id_wb_addr = 5'(rd);
    id_has_rs1 = 1; id_rs1_addr = 5'(base);
  endtask

  task automatic set_alu(input int rd, input int a, input int b);
    idle();
    id_valid = 1; id_wb_flag = 1; id_wb_addr = 5'(rd);
    id_has_rs1 = 1; id_rs1_addr = 5'(a); id_has_rs2 = 1; id_rs2_addr = 5'(b);
  endtask

  task automatic set_store(input int data, input int base);
    idle();
    id_valid = 1; id_is_store = 1;
    id_has_rs1 = 1; id_rs1_addr = 5'(base); id_has_rs2 = 1; id_rs2_addr = 5'(data);
  endtask

  function automatic bit waits(input int m, input int r);
    int hit;
    hit = (load_done && int'(load_done_addr[3:0]) == r) ? 1 : 0;
    return (pend_m[m][r] - hit) != 0;
  endfunction

  // Check the combinational decode and state outputs, then advance one edge.
  task automatic cycle();
    bit hz1, hz2, full, st [2];
    int r1, r2, rd, dn;
    #1;
    r1 = int'(id_rs1_addr[3:0]); r2 = int'(id_rs2_addr[3:0]);
    rd = int'(id_wb_addr[3:0]);  dn = int'(load_done_addr[3:0]);
    for (int m = 0; m < 2; m++) begin
      hz1  = id_valid && id_has_rs1 && r1 != 0 && waits(m, r1);
      hz2  = id_valid && id_has_rs2 && r2 != 0 && waits(m, r2);
      if (m == 1 && id_is_store && !hz1) hz2 = 0;
      full = id_valid && id_is_load && id_wb_flag && rd != 0 && pend_m[m][rd] == 3;
      st[m] = hz1 || hz2 || full;
      check_eq($sformatf("hazard_rs1[%0d]", m), 32'(hz1_v[m]), 32'(hz1));
      check_eq($sformatf("hazard_rs2[%0d]", m), 32'(hz2_v[m]), 32'(hz2));
      check_eq($sformatf("stall[%0d]", m), 32'(stall_v[m]), 32'(st[m]));
      check_eq($sformatf("id_ready[%0d]", m), 32'(id_ready_v[m]), 32'(!st[m]));
      check_eq($sformatf("stall_cnt[%0d]", m), scnt_v[m], scnt_m[m]);
      check_eq($sformatf("sb_err[%0d]", m), 32'(err_v[m]), 32'(err_m[m]));
    end
    @(posedge clock);
    for (int m = 0; m < 2; m++) begin
      bit issue;
      issue = id_valid && !st[m] && !flush;
      for (int r = 1; r < 16; r++) begin
        bit inc, dec;
        inc = issue && id_is_load && id_wb_flag && rd == r;
        dec = load_done && dn == r;
        if (inc && !dec) begin
          if (pend_m[m][r] == 3) err_m[m] = 1; else pend_m[m][r]++;
        end else if (dec && !inc) begin
          if (pend_m[m][r] == 0) err_m[m] = 1; else pend_m[m][r]--;
        end
      end
      if (st[m]) scnt_m[m]++;
    end
    #1;
  endtask

  // Asynchronous reset between edges; outputs must clear before the next edge.
  task automatic do_reset();
    load_done = 0;
    reset = 1;
    #2;
    for (int m = 0; m < 2; m++) begin
      for (int r = 0; r < 16; r++) pend_m[m][r] = 0;
      scnt_m[m] = 0; err_m[m] = 0;
      check_eq($sformatf("rst_stall[%0d]", m), 32'(stall_v[m]), 32'd0);
      check_eq($sformatf("rst_stall_cnt[%0d]", m), scnt_v[m], 32'd0);
      check_eq($sformatf("rst_sb_err[%0d]", m), 32'(err_v[m]), 32'd0);
    end
    #3 reset = 0;
  endtask

  initial begin
    logic [31:0] base_cnt;
    pend_cnt_t   tmp;
    idle();
    for (int m = 0; m < 2; m++) begin
      for (int r = 0; r < 16; r++) pend_m[m][r] = 0;
      scnt_m[m] = 0; err_m[m] = 0;
    end
    #7;
    check_eq("reset_id_ready", 32'(id_ready_v[0]), 32'd1);
    check_eq("reset_hazard_rs1", 32'(hz1_v[0]), 32'd0);
    check_eq("reset_hazard_rs2", 32'(hz2_v[0]), 32'd0);
    do_reset();

    // Load-use on rs1: one stall cycle, released by load_done in the same cycle.
    set_load(5, 1); cycle();
    set_alu(6, 5, 1); cycle();
    check_eq("tp1_stall_cnt", scnt_v[0], 32'd1);
    load_done = 1; load_done_addr = 5; cycle();
    check_eq("tp1_stall_cnt_after", scnt_v[0], 32'd1);

    // Independent ALU op does not stall.
    do_reset();
    set_load(5, 1); cycle();
    set_alu(6, 1, 2); cycle();
    check_eq("tp2_no_stall", 32'(stall_v[0]), 32'd0);
    idle(); load_done = 1; load_done_addr = 5; cycle();
    check_eq("tp2_stall_cnt", scnt_v[0], 32'd0);

    // Store data hazard: only mode 0 stalls; store base hazard stalls both.
    set_load(5, 1); cycle();
    set_store(5, 3); #1;
    check_eq("tp3_sw_data_nofwd", 32'(stall_v[0]), 32'd1);
    check_eq("tp3_sw_data_fwd", 32'(stall_v[1]), 32'd0);
    cycle();
    set_store(7, 5); #1;
    check_eq("tp3_sw_base_nofwd", 32'(stall_v[0]), 32'd1);
    check_eq("tp3_sw_base_fwd", 32'(stall_v[1]), 32'd1);
    cycle();
    idle(); load_done = 1; load_done_addr = 5; cycle();

    // Three outstanding loads to x5 fill the counter; the fourth sees full.
    do_reset();
    for (int k = 0; k < 3; k++) begin set_load(5, 2); cycle(); end
    set_load(5, 2); #1;
    check_eq("tp4_full_stall", 32'(stall_v[0]), 32'd1);
    check_eq("tp4_full_ready", 32'(id_ready_v[0]), 32'd0);
    cycle();
    idle();
    for (int k = 0; k < 3; k++) begin load_done = 1; load_done_addr = 5; cycle(); end

    // Simultaneous issue and completion on x4, then an underflow.
    do_reset();
    set_load(4, 1); cycle();
    set_load(4, 1); load_done = 1; load_done_addr = 4; cycle();
    idle(); load_done = 1; load_done_addr = 4; cycle();
    check_eq("tp5_no_err_yet", 32'(err_v[0]), 32'd0);
    idle(); load_done = 1; load_done_addr = 4; cycle();
    check_eq("tp5_underflow_err", 32'(err_v[0]), 32'd1);
    set_alu(6, 4, 0); #1;
    check_eq("tp5_pend_stays_zero", 32'(stall_v[0]), 32'd0);
    cycle();

    // Reset with pend[3] = 2 while a dependent op is stalled.
    set_load(3, 1); cycle();
    set_load(3, 1); cycle();
    set_alu(6, 3, 0); cycle();
    base_cnt = scnt_v[0];
    check_eq("tp6_stalled_before", base_cnt, 32'd1);
    do_reset();
    cycle();

    // Random traffic, including flushes, bit-4 noise and occasional resets.
    for (int n = 0; n < 1500; n++) begin
      idle();
      id_valid    = ($urandom_range(0, 3) != 0);
      flush       = ($urandom_range(0, 7) == 0);
      id_has_rs1  = $urandom_range(0, 1);
      id_has_rs2  = $urandom_range(0, 1);
      id_rs1_addr = 5'($urandom_range(0, 7)) | (($urandom_range(0, 15) == 0) ? 5'h10 : 5'h0);
      id_rs2_addr = 5'($urandom_range(0, 7));
      case ($urandom_range(0, 2))
        0: begin id_is_load = 1; id_wb_flag = ($urandom_range(0, 7) != 0); end
        1: id_is_store = 1;
        default: id_wb_flag = $urandom_range(0, 1);
      endcase
      id_wb_addr = 5'($urandom_range(0, 7));
      if ($urandom_range(0, 2) == 0) begin
        int r;
        r = $urandom_range(1, 7);
        if (pend_m[0][r] > 0 || $urandom_range(0, 15) == 0) begin
          load_done = 1;
          tmp = 2'($urandom_range(0, 1));
          load_done_addr = 5'(r) | ((tmp[0]) ? 5'h10 : 5'h0);
        end
      end
      cycle();
      if (n % 400 == 399) do_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
